// File: rtl/irq_ctrl_pkg.sv
// Register map and line-mode encoding for the interrupt controller.
package irq_ctrl_pkg;

   localparam logic [2:0] IRQ_R_PENDING = 3'd0;
   localparam logic [2:0] IRQ_R_MASK    = 3'd1;
   localparam logic [2:0] IRQ_R_MODE    = 3'd2;
   localparam logic [2:0] IRQ_R_COUNT   = 3'd3;
   localparam logic [2:0] IRQ_R_COMPARE = 3'd4;
   localparam logic [2:0] IRQ_R_STATUS  = 3'd5;

   typedef enum logic {
      LEVEL = 1'b0,
      EDGE  = 1'b1
   } irqmode_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: reports whether any bit is set and the index of the highest one.
module irq_prio_enc #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [W-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Nested-priority interrupt controller with per-line level/edge mode and a
// count/compare timer feeding one line; presents a single request plus ID to CP0.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_IRQ      = 8,
   parameter int TIMER_IRQ    = NUM_IRQ - 1,
   parameter int TIMER_PERIOD = 16,
   parameter int IDW          = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq_req,
   output logic [IDW-1:0]     irq_id,
   input  logic               irq_ack,
   input  logic               irq_eoi,
   input  logic               reg_we,
   input  logic [2:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata
);

   localparam int PSW = $clog2(TIMER_PERIOD);

   logic [NUM_IRQ-1:0] pending_q, mask_q, mode_q, prev_q, in_service_q;
   logic [NUM_IRQ-1:0] pending_n, in_service_n, pending_vis;
   logic [NUM_IRQ-1:0] edge_mode, edge_set, clr_vec, ack_onehot, cand;
   logic [31:0]        count_q, compare_q;
   logic [PSW-1:0]     prescale_q;
   logic               timer_hit_q, timer_hit_n, ge_q;
   logic               cand_valid, is_valid, ack_fire, count_match, prescale_wrap;
   logic [IDW-1:0]     hp_idx, hs_idx;
   logic [NUM_IRQ+7:0] status_rd;
   logic               wr_pending, wr_mask, wr_mode, wr_count, wr_compare, wr_status;

   assign wr_pending = reg_we && (reg_addr == IRQ_R_PENDING);
   assign wr_mask    = reg_we && (reg_addr == IRQ_R_MASK);
   assign wr_mode    = reg_we && (reg_addr == IRQ_R_MODE);
   assign wr_count   = reg_we && (reg_addr == IRQ_R_COUNT);
   assign wr_compare = reg_we && (reg_addr == IRQ_R_COMPARE);
   assign wr_status  = reg_we && (reg_addr == IRQ_R_STATUS);

   // The timer match is kept apart from the line logic so it holds regardless of MODE.
   assign pending_vis = pending_q | (NUM_IRQ'(timer_hit_q) << TIMER_IRQ);
   assign cand        = pending_vis & mask_q;

   irq_prio_enc #(.N(NUM_IRQ), .W(IDW)) u_cand_enc (
      .req   (cand),
      .valid (cand_valid),
      .idx   (hp_idx)
   );

   irq_prio_enc #(.N(NUM_IRQ), .W(IDW)) u_is_enc (
      .req   (in_service_q),
      .valid (is_valid),
      .idx   (hs_idx)
   );

   assign irq_req  = ge_q & cand_valid & (~is_valid | (hp_idx > hs_idx));
   assign irq_id   = hp_idx;
   assign ack_fire = irq_ack & irq_req;

   assign count_match   = (compare_q != 32'd0) && (count_q == compare_q);
   assign prescale_wrap = (prescale_q == PSW'(TIMER_PERIOD - 1));

   always_comb begin
      edge_mode = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         edge_mode[i] = (irqmode_e'(mode_q[i]) == EDGE);
      end
      edge_set   = irq_in & ~prev_q;
      ack_onehot = ack_fire ? (NUM_IRQ'(1) << irq_id) : '0;
      clr_vec    = ack_onehot | (wr_pending ? reg_wdata[NUM_IRQ-1:0] : '0);
      // A fresh edge beats any clear landing on the same line in the same cycle.
      pending_n  = (edge_mode & ((pending_q & ~clr_vec) | edge_set)) |
                   (~edge_mode & irq_in);
      timer_hit_n = wr_compare ? 1'b0 : (count_match | timer_hit_q);
   end

   // EOI retires the old highest entry before the ack adds the new one.
   always_comb begin
      in_service_n = in_service_q;
      if (irq_eoi && is_valid) in_service_n = in_service_n & ~(NUM_IRQ'(1) << hs_idx);
      if (ack_fire)            in_service_n = in_service_n | ack_onehot;
      if (wr_status)           in_service_n = NUM_IRQ'(reg_wdata >> 8);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q    <= '0;
         mask_q       <= '0;
         mode_q       <= '0;
         prev_q       <= '0;
         in_service_q <= '0;
         count_q      <= '0;
         compare_q    <= '0;
         prescale_q   <= '0;
         timer_hit_q  <= 1'b0;
         ge_q         <= 1'b0;
      end else begin
         pending_q    <= pending_n;
         prev_q       <= irq_in;
         in_service_q <= in_service_n;
         timer_hit_q  <= timer_hit_n;
         prescale_q   <= prescale_wrap ? '0 : prescale_q + PSW'(1);
         if (wr_count)          count_q <= reg_wdata;
         else if (prescale_wrap) count_q <= count_q + 32'd1;
         if (wr_mask)    mask_q    <= reg_wdata[NUM_IRQ-1:0];
         if (wr_mode)    mode_q    <= reg_wdata[NUM_IRQ-1:0];
         if (wr_compare) compare_q <= reg_wdata;
         if (wr_status)  ge_q      <= reg_wdata[0];
      end
   end

   assign status_rd = {in_service_q, 7'd0, ge_q};

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         IRQ_R_PENDING: reg_rdata = 32'(pending_vis);
         IRQ_R_MASK:    reg_rdata = 32'(mask_q);
         IRQ_R_MODE:    reg_rdata = 32'(mode_q);
         IRQ_R_COUNT:   reg_rdata = count_q;
         IRQ_R_COMPARE: reg_rdata = compare_q;
         IRQ_R_STATUS:  reg_rdata = 32'(status_rd);
         default:       reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued as stimulus is driven
// and popped against DUT observations at the end of each scenario.
module tb_irq_ctrl;

   localparam int NUM_IRQ      = 8;
   localparam int TIMER_PERIOD = 4;
   localparam int IDW          = $clog2(NUM_IRQ);

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_IRQ-1:0] irq_in;
   logic               irq_req;
   logic [IDW-1:0]     irq_id;
   logic               irq_ack, irq_eoi, reg_we;
   logic [2:0]         reg_addr;
   logic [31:0]        reg_wdata, reg_rdata;

   typedef struct {
      string       name;
      logic [31:0] val;
   } item_t;

   item_t       exp_q[$];
   logic [31:0] obs_q[$];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   irq_ctrl #(
      .NUM_IRQ      (NUM_IRQ),
      .TIMER_IRQ    (NUM_IRQ - 1),
      .TIMER_PERIOD (TIMER_PERIOD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .irq_eoi   (irq_eoi),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_we = 1'b0; reg_wdata = '0;
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
      reg_addr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic expect_val(input string n, input logic [31:0] v);
      item_t it;
      it.name = n;
      it.val  = v;
      exp_q.push_back(it);
   endtask

   task automatic observe(input logic [31:0] v);
      obs_q.push_back(v);
   endtask

   task automatic observe_req_id();
      observe({31'd0, irq_req});
      observe(32'(irq_id));
   endtask

   task automatic test_reset();
      item_t e; logic [31:0] o, d;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      expect_val("reset_req", 0); expect_val("reset_id", 0);
      expect_val("reset_pending", 0); expect_val("reset_status", 0); expect_val("reset_count", 0);
      observe_req_id();
      read_reg(3'd0, d); observe(d);
      read_reg(3'd5, d); observe(d);
      read_reg(3'd3, d); observe(d);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_level();
      item_t e; logic [31:0] o;
      write_reg(3'd1, 32'h08);
      write_reg(3'd5, 32'h01);
      irq_in[3] = 1'b1;
      expect_val("level_no_early_req", 0);
      #1; observe({31'd0, irq_req});
      expect_val("level_req", 1); expect_val("level_id", 3);
      tick(); observe_req_id();
      irq_in[3] = 1'b0;
      expect_val("level_drop_req", 0);
      tick(); observe({31'd0, irq_req});
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_edge();
      item_t e; logic [31:0] o, d;
      write_reg(3'd2, 32'h04);
      write_reg(3'd1, 32'h04);
      irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0; tick();
      expect_val("edge_sticky_pending", 32'h04); expect_val("edge_req", 1); expect_val("edge_id", 2);
      read_reg(3'd0, d); observe(d); observe_req_id();
      irq_ack = 1'b1;
      expect_val("edge_ack_pending", 0); expect_val("edge_ack_status", 32'h401); expect_val("edge_ack_req", 0);
      tick(); irq_ack = 1'b0;
      read_reg(3'd0, d); observe(d); read_reg(3'd5, d); observe(d); observe({31'd0, irq_req});
      reg_we = 1'b1; reg_addr = 3'd0; reg_wdata = 32'h04; irq_in[2] = 1'b1;
      expect_val("edge_set_beats_clear", 32'h04);
      tick(); reg_we = 1'b0; reg_wdata = '0; irq_in[2] = 1'b0;
      read_reg(3'd0, d); observe(d);
      expect_val("edge_write_clear", 0);
      write_reg(3'd0, 32'h04);
      read_reg(3'd0, d); observe(d);
      expect_val("edge_status_restore", 32'h01);
      write_reg(3'd5, 32'h01);
      read_reg(3'd5, d); observe(d);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_nesting();
      item_t e; logic [31:0] o, d;
      write_reg(3'd1, 32'h26);
      irq_in[2] = 1'b1; tick();
      irq_in[2] = 1'b0; irq_ack = 1'b1;
      expect_val("nest_ack2_status", 32'h401);
      tick(); irq_ack = 1'b0;
      read_reg(3'd5, d); observe(d);
      irq_in[1] = 1'b1;
      expect_val("nest_low_blocked", 0);
      tick(); observe({31'd0, irq_req});
      irq_in[5] = 1'b1;
      expect_val("nest_high_req", 1); expect_val("nest_high_id", 5);
      tick(); observe_req_id();
      irq_ack = 1'b1; irq_in[5] = 1'b0;
      expect_val("nest_ack5_status", 32'h2401);
      tick(); irq_ack = 1'b0;
      read_reg(3'd5, d); observe(d);
      irq_eoi = 1'b1;
      expect_val("nest_eoi1_status", 32'h401); expect_val("nest_eoi1_req", 0);
      tick(); irq_eoi = 1'b0;
      read_reg(3'd5, d); observe(d); observe({31'd0, irq_req});
      irq_eoi = 1'b1;
      expect_val("nest_eoi2_status", 32'h001); expect_val("nest_eoi2_req", 1); expect_val("nest_eoi2_id", 1);
      tick(); irq_eoi = 1'b0;
      read_reg(3'd5, d); observe(d); observe_req_id();
      irq_in[1] = 1'b0; tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_eoi_ack();
      item_t e; logic [31:0] o, d;
      write_reg(3'd5, 32'h401);
      write_reg(3'd1, 32'h40);
      irq_in[6] = 1'b1;
      expect_val("eoiack_req", 1); expect_val("eoiack_id", 6);
      tick(); observe_req_id();
      irq_ack = 1'b1; irq_eoi = 1'b1;
      expect_val("eoiack_status", 32'h4001);
      tick(); irq_ack = 1'b0; irq_eoi = 1'b0;
      read_reg(3'd5, d); observe(d);
      irq_in[6] = 1'b0;
      write_reg(3'd5, 32'h01);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_gating();
      item_t e; logic [31:0] o, d;
      write_reg(3'd1, 32'h10);
      irq_in[4] = 1'b1;
      expect_val("gate_req", 1); expect_val("gate_id", 4);
      tick(); observe_req_id();
      expect_val("gate_masked_req", 0); expect_val("gate_masked_pending", 32'h10);
      write_reg(3'd1, 32'h00);
      observe({31'd0, irq_req}); read_reg(3'd0, d); observe(d);
      write_reg(3'd1, 32'h10);
      expect_val("gate_ge_off_req", 0);
      write_reg(3'd5, 32'h00);
      observe({31'd0, irq_req});
      irq_in[4] = 1'b0;
      write_reg(3'd5, 32'h01);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_regs();
      item_t e; logic [31:0] o, d;
      expect_val("regs_addr6", 0); expect_val("regs_addr7", 0);
      write_reg(3'd6, 32'hFFFF_FFFF);
      read_reg(3'd6, d); observe(d); read_reg(3'd7, d); observe(d);
      expect_val("regs_mask_width", 32'hFF);
      write_reg(3'd1, 32'hFFFF_FFFF);
      read_reg(3'd1, d); observe(d);
      expect_val("regs_count_write", 32'h1234_5678);
      write_reg(3'd3, 32'h1234_5678);
      read_reg(3'd3, d); observe(d);
      expect_val("regs_compare_write", 32'h0000_ABCD);
      write_reg(3'd4, 32'h0000_ABCD);
      read_reg(3'd4, d); observe(d);
      write_reg(3'd4, 32'h0);
      write_reg(3'd1, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_reset_mid();
      item_t e; logic [31:0] o, d;
      write_reg(3'd2, 32'h00);
      write_reg(3'd5, 32'h201);
      write_reg(3'd1, 32'h10);
      irq_in[4] = 1'b1;
      expect_val("rstmid_req_before", 1);
      tick(); observe({31'd0, irq_req});
      rst = 1'b1;
      expect_val("rstmid_req", 0); expect_val("rstmid_id", 0);
      expect_val("rstmid_status", 0); expect_val("rstmid_pending", 0); expect_val("rstmid_mask", 0);
      tick();
      observe_req_id();
      read_reg(3'd5, d); observe(d); read_reg(3'd0, d); observe(d); read_reg(3'd1, d); observe(d);
      rst = 1'b0; irq_in = '0;
      tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   task automatic test_timer();
      item_t e; logic [31:0] o, d;
      rst = 1'b1; tick(); rst = 1'b0;
      write_reg(3'd4, 32'd3);
      for (int i = 0; i < 10; i++) tick();
      expect_val("timer_count_2", 2); expect_val("timer_no_early", 0);
      read_reg(3'd3, d); observe(d); read_reg(3'd0, d); observe(d);
      tick();
      expect_val("timer_count_3", 3);
      read_reg(3'd3, d); observe(d);
      tick();
      expect_val("timer_match_pending", 32'h80);
      read_reg(3'd0, d); observe(d);
      expect_val("timer_write_beats_match", 0);
      write_reg(3'd4, 32'd3);
      read_reg(3'd0, d); observe(d);
      write_reg(3'd4, 32'd0);
      for (int i = 0; i < 20; i++) tick();
      expect_val("timer_disabled", 0);
      read_reg(3'd0, d); observe(d);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (obs_q.size() > 0) o = obs_q.pop_front();
         checks++;
         if (o !== e.val) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val);
         end
      end
   endtask

   initial begin
      rst = 1'b1; irq_in = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
      reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
      test_reset();
      test_level();
      test_edge();
      test_nesting();
      test_eoi_ack();
      test_gating();
      test_regs();
      test_reset_mid();
      test_timer();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
